// File: rtl/mask_packer_if.sv
// mask_packer_if: bit-stream input and packed-word output of mask_packer.
// slave = packer side, master = producer/consumer side.
interface mask_packer_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
);
  localparam int NB_W = $clog2(WORD_W) + 1;

  logic              in_valid;
  logic              in_bit;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic [NB_W-1:0]   out_nbits;
  logic              out_last;
  logic [CNT_W-1:0]  out_total;
  logic              out_ready;
  logic [NB_W-1:0]   out_ones;

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_data, out_nbits,
    output out_last, out_total, out_ones
  );

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_nbits,
    input  out_last, out_total, out_ones
  );
endinterface

// File: rtl/mask_packer.sv
// mask_packer: packs a 1-bit result stream LSB-first into WORD_W-bit
// mask words, buffered in a FWFT FIFO with per-column last/total.
// Ports: clk, reset (sync, active-high), io (mask_packer_if.slave):
//   in_valid/in_bit/in_last/in_ready  result-bit input stream
//   out_valid/out_ready/out_data/out_nbits/out_last/out_total/out_ones
// Option: define MASK_PACKER_POPCOUNT_EN to store a per-word popcount
//   on out_ones; otherwise out_ones is tied to 0.
module mask_packer #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input logic           clk,
  input logic           reset,
  mask_packer_if.slave  io
);
  localparam int IDX_W = $clog2(WORD_W);
  localparam int NB_W  = IDX_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [NB_W-1:0]   nbits;
    logic              last;
    logic [CNT_W-1:0]  total;
  } entry_t;

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [FC_W-1:0]   cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];

  logic              accept, push, pop;
  logic [WORD_W-1:0] word_new;
  logic [CNT_W-1:0]  col_inc;
  entry_t            ent_new;

  assign accept = io.in_valid && io.in_ready;
  assign pop    = (cnt_q != '0) && io.out_ready;

  always_comb begin
    acc_d    = acc_q;
    idx_d    = idx_q;
    col_d    = col_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    mem_d    = mem_q;
    push     = 1'b0;
    ent_new  = '0;
    word_new = acc_q | ({{(WORD_W-1){1'b0}}, io.in_bit} << idx_q);
    col_inc  = col_q + CNT_W'(1);

    if (accept) begin
      if (idx_q == IDX_W'(WORD_W-1) || io.in_last) begin
        push          = 1'b1;
        ent_new.data  = word_new;
        ent_new.nbits = NB_W'(idx_q) + NB_W'(1);
        ent_new.last  = io.in_last;
        ent_new.total = io.in_last ? col_inc : '0;
        acc_d         = '0;
        idx_d         = '0;
        col_d         = io.in_last ? '0 : col_inc;
      end else begin
        acc_d = word_new;
        idx_d = idx_q + IDX_W'(1);
        col_d = col_inc;
      end
    end

    if (push) begin
      mem_d[wr_q] = ent_new;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    cnt_d = cnt_q + FC_W'(push) - FC_W'(pop);
    // Mirrors the next count exactly, so a push in the ready cycle
    // always finds a free slot.
    in_ready_d = (cnt_d < FC_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      idx_q      <= '0;
      col_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      mem_q      <= mem_d;
    end
  end

  // Held low while reset is asserted; the flop is already 1 afterwards.
  assign io.in_ready  = in_ready_q && !reset;
  assign io.out_valid = (cnt_q != '0);
  assign io.out_data  = mem_q[rd_q].data;
  assign io.out_nbits = mem_q[rd_q].nbits;
  assign io.out_last  = mem_q[rd_q].last;
  assign io.out_total = mem_q[rd_q].total;

`ifdef MASK_PACKER_POPCOUNT_EN
  logic [NB_W-1:0] ones_q [FIFO_DEPTH];
  logic [NB_W-1:0] ones_d [FIFO_DEPTH];
  logic [NB_W-1:0] ones_new;

  always_comb begin
    ones_new = '0;
    for (int i = 0; i < WORD_W; i++) begin
      ones_new = ones_new + NB_W'(word_new[i]);
    end
    ones_d = ones_q;
    if (push) ones_d[wr_q] = ones_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) ones_q[i] <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign io.out_ones = ones_q[rd_q];
`else
  assign io.out_ones = '0;
`endif
endmodule

// File: tb/tb_mask_packer.sv
// tb_mask_packer: randomized + directed scoreboard bench for mask_packer
// (WORD_W=8, FIFO_DEPTH=4) against a column-level reference model.
module tb_mask_packer;
  localparam int WW = 8;
  localparam int FD = 4;
  localparam int CW = 32;

  typedef struct {
    int data;
    int nbits;
    int last;
    int total;
    int ones;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   rmode = 0;

  exp_t exp_q[$];
  bit   cur_bits[$];
  int   col_cnt = 0;

  mask_packer_if #(.WORD_W(WW), .CNT_W(CW)) io ();

  mask_packer #(.WORD_W(WW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  // Reference model: a column is a list of bits; every 8 of them, or
  // the column end, becomes one word with bit k = k-th element.
  task automatic model_accept(input bit b, input bit l);
    exp_t e;
    cur_bits.push_back(b);
    col_cnt++;
    if (cur_bits.size() == WW || l) begin
      e.data = 0;
      e.ones = 0;
      for (int k = 0; k < cur_bits.size(); k++) begin
        e.data += int'(cur_bits[k]) * (2 ** k);
        e.ones += int'(cur_bits[k]);
      end
      e.nbits = cur_bits.size();
      e.last  = int'(l);
      e.total = l ? col_cnt : 0;
`ifndef MASK_PACKER_POPCOUNT_EN
      e.ones = 0;
`endif
      exp_q.push_back(e);
      cur_bits.delete();
      if (l) col_cnt = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic send(input bit b, input bit l);
    bit r;
    bit acc;
    acc = 1'b0;
    io.in_valid = 1'b1;
    io.in_bit   = b;
    io.in_last  = l;
    for (int n = 0; n < 200 && !acc; n++) begin
      r = io.in_ready;
      @(posedge clk);
      if (r) begin
        model_accept(b, l);
        acc = 1'b1;
      end
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    if (!acc) begin
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0");
    end
  endtask

  task automatic send_byte(input int v, input bit last_on_8);
    for (int k = 0; k < 8; k++) begin
      send(v[k], last_on_8 && k == 7);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io.in_valid = 1'b0;
    exp_q.delete();
    cur_bits.delete();
    col_cnt = 0;
    @(negedge clk);
    #2;
    check("rst_in_ready", int'(io.in_ready), 0);
    check("rst_out_valid", int'(io.out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("post_rst_in_ready", int'(io.in_ready), 1);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(negedge clk);
      case (rmode)
        1: io.out_ready = ~io.out_ready;
        2: io.out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Monitor: a word is consumed at the next posedge when valid&&ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: data=%0h nbits=%0d",
                   io.out_data, io.out_nbits);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(io.out_data), e.data);
          check("out_nbits", int'(io.out_nbits), e.nbits);
          check("out_last", int'(io.out_last), e.last);
          check("out_total", int'(io.out_total), e.total);
          check("out_ones", int'(io.out_ones), e.ones);
        end
      end
    end
  end

  initial begin
    io.in_valid  = 1'b0;
    io.in_bit    = 1'b0;
    io.in_last   = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    #2;
    check("rst_out_nbits", int'(io.out_nbits), 0);
    check("rst_out_total", int'(io.out_total), 0);
    check("rst_out_ones", int'(io.out_ones), 0);
    @(negedge clk);
    do_reset();

    // word ordering: 1,0,1,1,0,0,0,1 -> 0x8D
    send_byte(8'h8D, 1'b0);
    drain("order");

    // partial last: 11 ones
    for (int i = 0; i < 11; i++) send(1'b1, i == 10);
    drain("partial");

    // full word plus last
    send_byte(8'h5B, 1'b1);
    drain("full_last");

    // backpressure
    io.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(1'($urandom_range(0, 1)), 1'b0);
    repeat (3) @(negedge clk);
    #2;
    check("bp_in_ready", int'(io.in_ready), 0);
    check("bp_buffered", exp_q.size(), 4);
    @(negedge clk);
    io.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), i == 7);
    drain("bp");

    // reset mid-column
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    do_reset();
    send_byte(8'hA5, 1'b1);
    drain("mid_rst");

    // toggling ready with continuous input
    rmode = 1;
    for (int i = 0; i < 120; i++) send(1'($urandom_range(0, 1)),
                                       $urandom_range(0, 9) == 0);
    send(1'b0, 1'b1);
    rmode = 2;
    for (int i = 0; i < 200; i++) send(1'($urandom_range(0, 1)),
                                       $urandom_range(0, 12) == 0);
    send(1'b1, 1'b1);
    rmode = 0;
    io.out_ready = 1'b1;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
